// File: rtl/mult32x32_if.sv
// Operand/result bundle for the iterative 32x32 multiplier.
// The master issues start with operands; the slave reports busy and the product.
interface mult32x32_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [63:0] product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output product
    );
endinterface

// File: rtl/mult32x32.sv
// Unsigned 32x32 multiplier built on one shared 8x16 multiplier.
// Accumulates one shifted partial product per cycle over eight cycles.
module mult32x32 (
    input logic        clk,
    input logic        reset,
    mult32x32_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle,
        StA0B0,
        StA1B0,
        StA2B0,
        StA3B0,
        StA0B1,
        StA1B1,
        StA2B1,
        StA3B1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] product_q, product_d;

    logic [1:0]  byte_idx;
    logic        half_idx;
    logic [7:0]  a_byte;
    logic [15:0] b_half;
    logic [23:0] partial;
    logic [5:0]  shamt;
    logic [63:0] addend;

    // Operand slice selection for the current partial product.
    always_comb begin
        byte_idx = 2'd0;
        half_idx = 1'b0;
        unique case (state_q)
            StA0B0:  begin byte_idx = 2'd0; half_idx = 1'b0; end
            StA1B0:  begin byte_idx = 2'd1; half_idx = 1'b0; end
            StA2B0:  begin byte_idx = 2'd2; half_idx = 1'b0; end
            StA3B0:  begin byte_idx = 2'd3; half_idx = 1'b0; end
            StA0B1:  begin byte_idx = 2'd0; half_idx = 1'b1; end
            StA1B1:  begin byte_idx = 2'd1; half_idx = 1'b1; end
            StA2B1:  begin byte_idx = 2'd2; half_idx = 1'b1; end
            StA3B1:  begin byte_idx = 2'd3; half_idx = 1'b1; end
            default: begin byte_idx = 2'd0; half_idx = 1'b0; end
        endcase
    end

    assign a_byte  = a_q[{byte_idx, 3'b000} +: 8];
    assign b_half  = b_q[{half_idx, 4'b0000} +: 16];
    assign partial = a_byte * b_half;
    assign shamt   = {1'b0, byte_idx, 3'b000} + {1'b0, half_idx, 4'b0000};
    assign addend  = {40'd0, partial} << shamt;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    product_d = 64'd0;
                    state_d   = StA0B0;
                end
            end
            StA0B0:  state_d = StA1B0;
            StA1B0:  state_d = StA2B0;
            StA2B0:  state_d = StA3B0;
            StA3B0:  state_d = StA0B1;
            StA0B1:  state_d = StA1B1;
            StA1B1:  state_d = StA2B1;
            StA2B1:  state_d = StA3B1;
            StA3B1:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle) begin
            product_d = product_q + addend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            product_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.product = product_q;
endmodule

// File: tb/tb_mult32x32.sv
// Randomized self-checking bench for mult32x32 against a plain-arithmetic model.
module tb_mult32x32;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mult32x32_if bus ();

    mult32x32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
        end
    endtask

    // Starts an operation and follows it to completion; poke_at >= 0 issues a
    // stray start with fresh operands that many edges into the operation.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input int poke_at);
        logic [63:0] exp_p;
        int          n;
        exp_p     = {32'd0, op_a} * {32'd0, op_b};
        bus.a     = op_a;
        bus.b     = op_b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("busy_after_start", 64'(bus.busy), 64'd1);
        check_eq("product_cleared", bus.product, 64'd0);
        n = 0;
        while (bus.busy && n < 16) begin
            if (n == poke_at) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.a     = $urandom;
            bus.b     = $urandom;
            n++;
        end
        check_eq("latency", 64'(n), 64'd8);
        check_eq("product", bus.product, exp_p);
    endtask

    task automatic hold_check(input logic [63:0] exp_p);
        repeat (3) begin
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk);
            #1;
        end
        check_eq("hold_product", bus.product, exp_p);
        check_eq("hold_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        check_eq("reset_product", bus.product, 64'd0);
        reset = 1'b0;

        run_op(32'd211641329, 32'd326672953, -1);
        check_eq("directed_value", bus.product, 64'd69137497921274537);
        hold_check(64'd69137497921274537);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check_eq("max_value", bus.product, 64'hFFFF_FFFE_0000_0001);
        run_op(32'd0, 32'h1234_5678, -1);
        run_op(32'd1, 32'hFFFF_FFFF, -1);
        check_eq("one_times_max", bus.product, 64'h0000_0000_FFFF_FFFF);

        // Stray start mid-operation must not disturb the result.
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 3);
        hold_check(64'hDEAD_BEEF * 64'h0BAD_F00D);

        // Reset in the middle of an operation.
        bus.a     = 32'h8765_4321;
        bus.b     = 32'h1357_9BDF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_product", bus.product, 64'd0);
        run_op(32'h8765_4321, 32'h1357_9BDF, -1);

        // Reset wins over start on the same edge.
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check_eq("prio_busy", 64'(bus.busy), 64'd0);
        check_eq("prio_product", bus.product, 64'd0);
        @(posedge clk);
        #1;
        check_eq("prio_stays_idle", 64'(bus.busy), 64'd0);

        // Back-to-back operations, then randomized ones.
        run_op(32'h0001_0000, 32'h0001_0000, -1);
        run_op(32'h7FFF_FFFF, 32'h0000_0003, -1);
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, (i % 3 == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult32x32.md
MULT32X32 -- requirements
Module: mult32x32

Interface
- Parameters: none.
- REQ-001: The module SHALL run from one clock, and its reset SHALL be synchronous and active-high.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: reset  input  1  synchronous active-high reset.
- REQ-004: start  input  1  single-cycle request to begin a multiplication, sampled on a rising clk edge.
- REQ-005: a  input  32  unsigned multiplicand.
- REQ-006: b  input  32  unsigned multiplier.
- REQ-007: busy  output  1  high while a multiplication is in progress.
- REQ-008: product  output  64  registered unsigned result a*b.

Function
- REQ-009: The module SHALL compute the unsigned product iteratively with one shared 8x16 unsigned multiplier (a byte times b half-word), one partial product per cycle, 8 cycles in total.
- REQ-010: The FSM SHALL have states IDLE, A0B0, A1B0, A2B0, A3B0, A0B1, A1B1, A2B1, A3B1, and SHALL advance in that order, one state per clk edge.
- REQ-011: In IDLE with start=1 at a clk edge, the module SHALL latch a and b internally, clear product to 0, and go to A0B0; in IDLE with start=0 it SHALL stay in IDLE and hold product.
- REQ-012: In state AiBj (i=0..3, j=0..1), at the next clk edge, product SHALL become product + ((a_lat[8i+7:8i] * b_lat[16j+15:16j]) << (8i+16j)).
- REQ-013: All arithmetic SHALL be unsigned, and the accumulator SHALL be 64 bits wide; the final sum never overflows.
- REQ-014: After the A3B1 edge, the FSM SHALL return to IDLE, and product SHALL then equal a*b exactly.
- REQ-015: busy SHALL be a Moore output: 1 in every non-IDLE state and 0 in IDLE.
- REQ-016: Latency: if start is sampled at edge N, busy SHALL be high after edges N through N+7 and low after edge N+8; product SHALL be final after edge N+8.
- REQ-017: The result SHALL stay stable on product, with busy=0, until the next accepted start or reset.
- REQ-018: start SHALL be ignored while busy=1, and the operation in progress SHALL complete unaffected.
- REQ-019: Changes on a or b after the start edge SHALL NOT affect the result.
- REQ-020: Intermediate product values SHALL be visible during busy, but are meaningful only when busy falls.

Reset
- REQ-021: When reset=1 at a clk edge, the FSM SHALL go to IDLE, busy SHALL be 0 and product SHALL be 0, regardless of start.
- REQ-022: Reset during an operation SHALL abort it with no partial result retained.
- REQ-023: The latched operand registers SHALL reset to 0.
- REQ-024: reset SHALL take priority over start when both are high at the same edge.

Verification
- REQ-025: Release reset, then pulse start for one cycle with a=211641329 and b=326672953 -> busy high for exactly 8 cycles, then product=69137497921274537 with busy=0.
- REQ-026: a=0xFFFFFFFF, b=0xFFFFFFFF, start -> after 8 cycles, product=0xFFFFFFFE00000001.
- REQ-027: a=0 and b=0x12345678, and separately a=1 and b=0xFFFFFFFF -> product=0 and 0x00000000FFFFFFFF respectively, each after 8 cycles.
- REQ-028: Start a multiplication, then pulse start again and change a/b at cycle 3 -> the first result is unchanged and busy still falls after 8 cycles.
- REQ-029: Assert reset at cycle 4 of an operation -> busy=0 and product=0 on the next edge; a subsequent start computes correctly.
- REQ-030: Two back-to-back operations (start asserted the cycle after busy falls) -> both results correct, and product is cleared at the second start edge.
